rv_alu_pipe: RTL and testbench
==============================

RV_ALU_PIPE -- requirements
Module: rv_alu_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 2: number of pipeline stages between input acceptance and output; legal range 1..4.
REQ-003 Parameter NREG, default 32: architectural register count; rd width is 5.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-006 in_valid  input  1  decoded operation present.
REQ-007 in_ready  output  1  block can accept an operation this cycle.
REQ-008 in_opcode  input  7  RV opcode field.
REQ-009 in_funct3  input  3  RV funct3 field.
REQ-010 in_funct7  input  7  RV funct7 field.
REQ-011 in_rd  input  5  destination register index.
REQ-012 in_rs1_val  input  XLEN  operand A.
REQ-013 in_rs2_val  input  XLEN  operand B for R-type.
REQ-014 in_imm  input  XLEN  sign-extended immediate for I-type.
REQ-015 flush  input  1  synchronous kill of all in-flight operations.
REQ-016 out_valid  output  1  result present.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 out_rd, out_data, out_wen, out_illegal  output  5 / XLEN / 1 / 1  destination, result, register-write enable, undecodable-operation flag.
REQ-019 busy_mask  output  NREG  bit r set while any valid stage holds an op with wen=1 and rd=r.
REQ-020 retire_cnt  output  32  count of output transfers.

Function
REQ-021 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-022 Each stage SHALL hold a valid bit; stage k SHALL advance when stage k+1 is empty or advancing; the last stage advances on output transfer; bubbles SHALL collapse.
REQ-023 in_ready SHALL equal !valid[0] || stage 0 advancing, combinationally.
REQ-024 With out_ready held at 1, a result SHALL reach out_valid exactly DEPTH cycles after its input transfer; throughput SHALL be 1 op/cycle.
REQ-025 Results SHALL emerge in acceptance order; no op SHALL be dropped or duplicated under backpressure.
REQ-026 Opcode 0010011 (I-type) SHALL use B=in_imm; opcode 0110011 (R-type) SHALL use B=in_rs2_val.
REQ-027 funct3 decode: 000 ADD; R-type with funct7[5]=1 gives SUB, and I-type is always ADD; 001 SLL; 010 SLT signed; 011 SLTU unsigned; 100 XOR; 101 SRL, or SRA when funct7[5]=1; 110 OR; 111 AND.
REQ-028 Shift amount SHALL be B[log2(XLEN)-1:0]; add and sub SHALL wrap modulo 2^XLEN; SLT and SLTU SHALL produce 0 or 1, zero-extended.
REQ-029 Any other opcode SHALL produce out_illegal=1, out_wen=0, out_data=0, and SHALL still occupy a pipeline slot.
REQ-030 out_wen SHALL be 0 when rd=0; out_wen SHALL be 1 for every other legal op.
REQ-031 flush=1 SHALL clear all valid bits at the next edge; an input transfer in the same cycle SHALL be discarded; an output transfer in the same cycle SHALL still count.
REQ-032 busy_mask SHALL be combinational from stage contents, and bit 0 SHALL always be 0.
REQ-033 retire_cnt SHALL increment by 1 per output transfer and SHALL wrap from FFFFFFFF to 0.
REQ-034 Outputs while out_valid=0 SHALL hold their last values, and SHALL be 0 after reset.

Reset
REQ-035 While rst_n=0, all valid bits, busy_mask, retire_cnt, out_data, out_rd, out_wen, and out_illegal SHALL be 0, and in_ready SHALL be 1.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight ops without emitting them.

Verification
REQ-037 DEPTH=2, out_ready=1: ADDI rd=5, rs1=7, imm=-3 -> out_valid 2 cycles later with out_data=4, out_rd=5, out_wen=1, and busy_mask[5]=1 during flight.
REQ-038 R-type SUB with A=0, B=1 -> out_data=FFFFFFFF; SRA with A=80000000, B=4 -> F8000000; SLTU with A=1, B=FFFFFFFF -> 1; SLT with the same operands -> 0.
REQ-039 Stream 8 ops with out_ready=0 for 5 cycles -> in_ready drops after DEPTH accepts; after release, all 8 ops emerge in order and retire_cnt=8.
REQ-040 flush asserted with 2 ops in flight and in_valid=1 -> no out_valid next cycle, busy_mask=0, and the input op is lost.
REQ-041 Opcode 0000011, and ADDI with rd=0 -> out_illegal=1 with out_wen=0, and out_illegal=0 with out_wen=0, respectively.
REQ-042 rst_n pulsed low while the pipe is full -> all outputs 0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/rv_alu_pipe.sv
// RV32/64 integer ALU behind a DEPTH-stage elastic pipeline with valid/ready handshakes.
// The result is computed at acceptance; the stages carry it and collapse bubbles. busy_mask tracks pending rd writes.
module rv_alu_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_wen,
  output logic            out_illegal,
  output logic [NREG-1:0] busy_mask,
  output logic [31:0]     retire_cnt
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_rd  [DEPTH];
  logic [XLEN-1:0]  r_dat [DEPTH];
  logic [DEPTH-1:0] r_wen;
  logic [DEPTH-1:0] r_ill;
  logic [31:0]      r_retire;

  logic             w_is_r;
  logic             w_legal;
  logic [XLEN-1:0]  w_b;
  logic [SHW-1:0]   w_sh;
  logic [XLEN-1:0]  w_res;
  logic [XLEN-1:0]  w_dat;
  logic             w_wen;
  logic [DEPTH-1:0] w_adv;
  logic             w_hole;
  logic             w_acc;
  logic             w_ret;
  logic [NREG-1:0]  w_busy;
  logic             w_unused_f7;

  assign w_unused_f7 = ^{in_funct7[6], in_funct7[4:0]};

  always_comb begin
    w_is_r  = (in_opcode == OP_REG);
    w_legal = w_is_r || (in_opcode == OP_IMM);
    w_b     = w_is_r ? in_rs2_val : in_imm;
    w_sh    = w_b[SHW-1:0];
    w_res   = '0;
    case (in_funct3)
      3'b000: w_res = (w_is_r && in_funct7[5]) ? in_rs1_val - w_b : in_rs1_val + w_b;
      3'b001: w_res = in_rs1_val << w_sh;
      3'b010: w_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1_val) < $signed(w_b))};
      3'b011: w_res = {{(XLEN-1){1'b0}}, (in_rs1_val < w_b)};
      3'b100: w_res = in_rs1_val ^ w_b;
      3'b101: w_res = in_funct7[5] ? XLEN'($signed(in_rs1_val) >>> w_sh) : in_rs1_val >> w_sh;
      3'b110: w_res = in_rs1_val | w_b;
      3'b111: w_res = in_rs1_val & w_b;
      default: w_res = '0;
    endcase
    w_dat = w_legal ? w_res : '0;
    w_wen = w_legal && (in_rd != 5'd0);
  end

  // A stage moves forward iff some later stage is empty or the output is taking a result.
  always_comb begin
    w_adv  = '0;
    w_hole = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hole = out_ready;
      for (int j = k + 1; j < DEPTH; j++) begin
        w_hole = w_hole | ~r_vld[j];
      end
      w_adv[k] = r_vld[k] & w_hole;
    end
  end

  assign in_ready = ~r_vld[0] | w_adv[0];
  assign w_acc    = in_valid & in_ready;
  assign w_ret    = r_vld[DEPTH-1] & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wen    <= '0;
      r_ill    <= '0;
      r_retire <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k]  <= '0;
        r_dat[k] <= '0;
      end
    end else begin
      if (w_ret) r_retire <= r_retire + 32'd1;
      if (flush) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_acc | (r_vld[0] & ~w_adv[0]);
        for (int k = 1; k < DEPTH; k++) begin
          r_vld[k] <= w_adv[k-1] | (r_vld[k] & ~w_adv[k]);
        end
        // Payload only moves with a live op so the output side holds while idle.
        if (w_acc) begin
          r_rd[0]  <= in_rd;
          r_dat[0] <= w_dat;
          r_wen[0] <= w_wen;
          r_ill[0] <= ~w_legal;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if (w_adv[k-1]) begin
            r_rd[k]  <= r_rd[k-1];
            r_dat[k] <= r_dat[k-1];
            r_wen[k] <= r_wen[k-1];
            r_ill[k] <= r_ill[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_vld[k] && r_wen[k] && (r_rd[k] == 5'(r))) w_busy[r] = 1'b1;
      end
    end
  end

  assign busy_mask   = w_busy;
  assign out_valid   = r_vld[DEPTH-1];
  assign out_rd      = r_rd[DEPTH-1];
  assign out_data    = r_dat[DEPTH-1];
  assign out_wen     = r_wen[DEPTH-1];
  assign out_illegal = r_ill[DEPTH-1];
  assign retire_cnt  = r_retire;

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Bench for rv_alu_pipe: directed corner cases plus a random stream checked against an in-order queue model.
module tb_rv_alu_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int NREG  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_wen;
  logic            out_illegal;
  logic [NREG-1:0] busy_mask;
  logic [31:0]     retire_cnt;

  rv_alu_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_wen(out_wen), .out_illegal(out_illegal), .busy_mask(busy_mask), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] n_ret   = 0;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [31:0] a, input logic [31:0] rs2,
                                  input logic [31:0] imm);
    exp_t        e;
    logic [31:0] b;
    int          sh;
    longint      sa;
    longint      sb;
    b  = (opc == 7'h33) ? rs2 : imm;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.rd = rd;
    case (f3)
      3'd0: e.data = (opc == 7'h33 && f7[5]) ? a - b : a + b;
      3'd1: e.data = a << sh;
      3'd2: e.data = (sa < sb) ? 32'd1 : 32'd0;
      3'd3: e.data = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      3'd4: e.data = a ^ b;
      3'd5: e.data = f7[5] ? 32'(sa / (64'sd1 <<< sh) - ((sa < 0 && (sa % (64'sd1 <<< sh)) != 0) ? 1 : 0)) : a >> sh;
      3'd6: e.data = a | b;
      default: e.data = a & b;
    endcase
    if (opc != 7'h13 && opc != 7'h33) begin
      e.ill = 1'b1; e.wen = 1'b0; e.data = 32'd0;
    end else begin
      e.ill = 1'b0; e.wen = (rd != 5'd0);
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    in_valid = v; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1_val = a; in_rs2_val = b; in_imm = imm;
  endtask

  // Called at a falling edge with inputs driven; checks, updates the model, returns at the next falling edge.
  task automatic cycle();
    logic        acc;
    logic        ret;
    logic [31:0] m;
    #2;
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("out_rd", out_rd, q[0].rd);
        chk("out_data", out_data, q[0].data);
        chk("out_wen", out_wen, q[0].wen);
        chk("out_illegal", out_illegal, q[0].ill);
      end
    end
    m = 0;
    foreach (q[i]) if (q[i].wen) m[q[i].rd] = 1'b1;
    chk("busy_mask", busy_mask, m);
    chk("retire_cnt", retire_cnt, n_ret);
    acc = in_valid && in_ready;
    ret = out_valid && out_ready;
    if (ret) begin
      if (q.size() > 0) void'(q.pop_front());
      n_ret++;
    end
    if (acc && !flush) q.push_back(ref_op(in_opcode, in_funct3, in_funct7, in_rd, in_rs1_val, in_rs2_val, in_imm));
    if (flush) q.delete();
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] exp_data, input logic exp_wen, input logic exp_ill);
    int n;
    out_ready = 1'b1;
    drive(1'b1, opc, f3, f7, rd, a, b, imm);
    cycle();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      if (exp_wen) chk({tag, "_busy"}, busy_mask[rd], 1);
      cycle();
      n++;
    end
    chk({tag, "_latency"}, n, DEPTH);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_wen"}, out_wen, exp_wen);
    chk({tag, "_ill"}, out_illegal, exp_ill);
    cycle();
  endtask

  initial begin
    int          idx;
    int          seen;
    logic [31:0] base;
    logic [6:0]  opc;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy_mask, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("addi", 7'h13, 3'd0, 7'h00, 5'd5, 32'd7, 32'd0, 32'hFFFF_FFFD, 32'd4, 1'b1, 1'b0);
    run_one("sub", 7'h33, 3'd0, 7'h20, 5'd6, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_one("sra", 7'h33, 3'd5, 7'h20, 5'd7, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b1, 1'b0);
    run_one("srl", 7'h33, 3'd5, 7'h00, 5'd7, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b1, 1'b0);
    run_one("sltu", 7'h33, 3'd3, 7'h00, 5'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1, 1'b0);
    run_one("slt", 7'h33, 3'd2, 7'h00, 5'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0);
    run_one("load_illegal", 7'h03, 3'd2, 7'h00, 5'd10, 32'd5, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1);
    run_one("addi_rd0", 7'h13, 3'd0, 7'h00, 5'd0, 32'd5, 32'd0, 32'd6, 32'd11, 1'b0, 1'b0);

    // Backpressure: output blocked for the first five cycles while eight ops stream in.
    base = n_ret;
    idx = 0;
    for (int cyc = 0; cyc < 60 && !(idx == 8 && q.size() == 0); cyc++) begin
      out_ready = (cyc >= 5);
      if (idx < 8) drive(1'b1, 7'h13, 3'd0, 7'h00, 5'(idx + 1), 32'd100, 32'd0, 32'(idx));
      else in_valid = 1'b0;
      cycle();
      if (last_acc) begin
        idx++;
        if (idx == DEPTH && cyc < 4) chk("stall_in_ready", in_ready, 0);
      end
      if (cyc == 4) chk("stall_held", idx, DEPTH);
    end
    chk("stall_all_in", idx, 8);
    chk("stall_retire", retire_cnt, base + 32'd8);

    // Flush with two ops in flight and a third being offered.
    out_ready = 1'b0;
    drive(1'b1, 7'h13, 3'd0, 7'h00, 5'd3, 32'd1, 32'd0, 32'd1); cycle();
    drive(1'b1, 7'h13, 3'd0, 7'h00, 5'd4, 32'd2, 32'd0, 32'd2); cycle();
    chk("pre_flush_busy", busy_mask, 32'h18);
    drive(1'b1, 7'h13, 3'd0, 7'h00, 5'd9, 32'd3, 32'd0, 32'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy_mask, 0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      cycle();
    end
    chk("flush_nothing_emerges", seen, 0);

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      idx = $urandom_range(0, 9);
      opc = (idx < 5) ? 7'h13 : (idx < 9) ? 7'h33 : 7'h03;
      drive($urandom_range(0, 3) != 0, opc, 3'($urandom), 7'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("random_drained", q.size(), 0);

    // Asynchronous reset with a full pipe.
    out_ready = 1'b0;
    drive(1'b1, 7'h33, 3'd6, 7'h00, 5'd12, 32'hF0, 32'h0F, 32'd0); cycle();
    drive(1'b1, 7'h33, 3'd4, 7'h00, 5'd13, 32'hFF, 32'h0F, 32'd0); cycle();
    in_valid = 1'b0;
    chk("full_before_reset", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_rd", out_rd, 0);
    chk("arst_out_wen", out_wen, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_retire", retire_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    n_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("post_reset_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
